regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 40 ++++
 rtl/regfile_wb_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of writeback requests, issue-stage reservation/lookup and register
// file write port shared between the arbiter and its neighbours.
interface regfile_wb_arbiter_if;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;

    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;

    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic [4:0]  rd1_addr;
    logic [4:0]  rd2_addr;
    logic        stall;

    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        init_done;

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  rsv_valid, rsv_addr, rd1_addr, rd2_addr,
        output a_ready, b_ready, stall,
        output RegWrite, WriteReg, WriteData, init_done
    );

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output rsv_valid, rsv_addr, rd1_addr, rd2_addr,
        input  a_ready, b_ready, stall,
        input  RegWrite, WriteReg, WriteData, init_done
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester round-robin writeback arbiter for a 32x32 register file with
// a power-up clear sweep and a pending-write scoreboard driving issue stall.
module regfile_wb_arbiter (
    input  logic                 clock,
    input  logic                 reset_n,
    regfile_wb_arbiter_if.slave  bus
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ptr_q, ptr_d;
    logic [31:0] pending_q, pending_d;
    logic        regwrite_q, regwrite_d;
    logic [4:0]  writereg_q, writereg_d;
    logic [31:0] writedata_q, writedata_d;
    logic        init_done_q, init_done_d;

    logic        grant_a;
    logic        grant_b;
    logic        stall_c;

    // ptr_q low means A wins a tie, high means B wins a tie.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == ST_RUN) begin
            if (bus.a_valid && (!bus.b_valid || !ptr_q)) begin
                grant_a = 1'b1;
            end else if (bus.b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign pending_d[0] = 1'b0;

    // A reservation on the same edge as the retiring write wins, so the
    // newer producer keeps the register marked busy.
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_pending
            logic set_bit;
            logic clr_bit;
            assign set_bit = (state_q == ST_RUN) && bus.rsv_valid
                             && (bus.rsv_addr == 5'(gi));
            assign clr_bit = (grant_a && (bus.a_addr == 5'(gi)))
                             || (grant_b && (bus.b_addr == 5'(gi)));
            assign pending_d[gi] = set_bit | (pending_q[gi] & ~clr_bit);
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        regwrite_d  = 1'b0;
        writereg_d  = writereg_q;
        writedata_d = writedata_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                // Leave the sweep only once register 31 is on the write port.
                if (regwrite_q && (writereg_q == 5'd31)) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    regwrite_d  = 1'b1;
                    writereg_d  = cnt_q;
                    writedata_d = 32'h0;
                    cnt_d       = cnt_q + 5'd1;
                end
            end
            ST_RUN: begin
                if (grant_a) begin
                    ptr_d = 1'b1;
                    if (bus.a_addr != 5'd0) begin
                        regwrite_d  = 1'b1;
                        writereg_d  = bus.a_addr;
                        writedata_d = bus.a_data;
                    end
                end else if (grant_b) begin
                    ptr_d = 1'b0;
                    if (bus.b_addr != 5'd0) begin
                        regwrite_d  = 1'b1;
                        writereg_d  = bus.b_addr;
                        writedata_d = bus.b_data;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= 5'd0;
            ptr_q       <= 1'b0;
            pending_q   <= 32'h0;
            regwrite_q  <= 1'b0;
            writereg_q  <= 5'd0;
            writedata_q <= 32'h0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            pending_q   <= pending_d;
            regwrite_q  <= regwrite_d;
            writereg_q  <= writereg_d;
            writedata_q <= writedata_d;
            init_done_q <= init_done_d;
        end
    end

    // A write already on the port is not yet visible to a same-cycle read.
    always_comb begin
        stall_c = 1'b1;
        if (state_q == ST_RUN) begin
            stall_c = pending_q[bus.rd1_addr] | pending_q[bus.rd2_addr]
                      | (regwrite_q && (writereg_q != 5'd0)
                         && ((writereg_q == bus.rd1_addr)
                             || (writereg_q == bus.rd2_addr)));
        end
    end

    assign bus.a_ready   = grant_a;
    assign bus.b_ready   = grant_b;
    assign bus.stall     = stall_c;
    assign bus.RegWrite  = regwrite_q;
    assign bus.WriteReg  = writereg_q;
    assign bus.WriteData = writedata_q;
    assign bus.init_done = init_done_q;

endmodule
